uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one uart_transmitter instance between NUM_REQ byte-stream requesters inside the UART peripheral, for example the register-driven TDR path, a boot loader and a debug/trace source. It grants requesters round-robin, launches one byte per grant via the transmitter's tx_data_valid/tx_data inputs, then sequences on tx_busy until the frame completes. A start-timeout flags a transmitter that never goes busy, for example when the serial clock is disabled.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 4096, clk cycles allowed between launch and tx_busy rising (must exceed one sck period)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester byte-pending request; held with data until ack
data  input  8*NUM_REQ  byte of requester i at [8*i+7:8*i]
lock  input  NUM_REQ  keep-grant request (present only with UART_TX_ARB_LOCK_EN)
ack  output  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i accepted
grant_id  output  $clog2(NUM_REQ)  index of last/current granted requester
tx_data_valid  output  1  1-cycle launch pulse to transmitter
tx_data  output  8  latched byte to transmitter
tx_busy  input  1  transmitter busy
active  output  1  high in any state other than IDLE
timeout_err  output  1  1-cycle pulse on start timeout

Behaviour:
- Reset is decided as follows: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, ack=0, tx_data_valid=0, tx_data=0, timeout_err=0, timer=0, grant_id=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered except active, which is decoded from state.
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE with any req set at edge t:
  - Winner is the first set req scanning from grant_id+1 upward, wrapping at NUM_REQ-1 to 0.
  - At the same edge: tx_data<=winner byte, ack[winner]<=1, tx_data_valid<=1, grant_id<=winner, state<=LAUNCH.
  - ack and tx_data_valid are therefore both high for exactly the cycle after t.
- IDLE with no req set: stay in IDLE, all pulses 0.
- LAUNCH: unconditionally go to WAIT_START with timer=0. ack and tx_data_valid drop.
- WAIT_START:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise timer increments. When timer==START_TIMEOUT-1, pulse timeout_err and go to IDLE. The byte is dropped, not retried.
- WAIT_DONE: tx_busy=0 returns to IDLE. This gives at least one IDLE cycle between frames, and arbitration is re-evaluated there.
- tx_data stays stable from launch until the next grant.
- Arbitration samples req only in IDLE. A req dropped before ack is never granted, and a req raised mid-frame waits.
- A requester must keep req and data stable until it sees ack. After ack it may drop req or present its next byte, in which case it re-arbitrates at the next IDLE.
- ack is never asserted for more than one requester at a time.
- timer width is $clog2(START_TIMEOUT+1). timer never wraps and is cleared on entry to WAIT_START.
- tx_busy going high outside WAIT_START is ignored. In IDLE it blocks nothing.
- rst_n assertion mid-frame aborts immediately to reset values. The transmitter is reset by the same rst_n.

Optional Feature:
UART_TX_ARB_LOCK_EN
- Defined:
  - lock port exists.
  - In IDLE, if lock[grant_id]=1 and req[grant_id]=1, grant_id is re-granted regardless of the other requesters.
  - If lock[grant_id]=1 and req[grant_id]=0, the arbiter stays in IDLE granting nobody until either signal changes. This supports multi-byte messages.
  - A start timeout clears the lock effect for one arbitration: the next grant is round-robin.
- Undefined: lock port is absent and arbitration is pure round-robin.

Test Plan:
- Single byte: req=4'b0010, data[15:8]=0x5A.
  - Next cycle: ack=4'b0010, tx_data_valid=1, tx_data=0x5A, grant_id=1.
  - Model tx_busy high 3 cycles later for 20 cycles, then active=0 one cycle after busy falls.
- Round-robin: req=4'b1011 held and reasserted after each ack.
  - Grant order is 0,1,3,0,1,3 with exactly one ack per frame.
- Timeout: START_TIMEOUT=16, tx_busy tied 0.
  - timeout_err pulses exactly 17 cycles after tx_data_valid.
  - FSM returns to IDLE and the next req is granted.
- Late/early req: req[2] pulsed for 1 cycle during WAIT_DONE, then dropped.
  - No ack[2]; arbiter idles.
- Reset mid-frame: assert rst_n=0 in WAIT_DONE.
  - All outputs 0 and grant_id=3 immediately.
  - After release, req=4'b1111 is granted to 0 first.
- Lock (macro on): lock[2]=1 with req=4'b0110 for 3 bytes.
  - Grants 2,2,2.
  - Then lock[2]=0 and the next grant is 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one uart_transmitter between NUM_REQ
// byte-stream requesters. Each grant launches one byte, then the arbiter
// follows tx_busy until the frame ends. If tx_busy never rises within
// START_TIMEOUT cycles, a start-timeout pulse is raised and the byte is dropped.
//
// Optional build macro: UART_TX_ARB_LOCK_EN
//   Adds the lock input. While lock[grant_id] is set, the current owner keeps
//   the transmitter, so a requester can send a multi-byte message without
//   another requester's bytes being interleaved.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | arbitrate among pending requests
// LAUNCH     | ack and tx_data_valid pulse is visible this cycle
// WAIT_START | wait for tx_busy to rise, with the timeout running
// WAIT_DONE  | frame in flight, wait for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         lock,
`endif
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_data_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic [GW-1:0]        grant_nxt;
  logic                 valid_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 timeout_nxt;
  logic [GW-1:0]        rr_id;
  logic [GW-1:0]        win_id;
  logic                 win_go;

  // Round-robin pick: the first set req after grant_id, wrapping at NUM_REQ-1.
  // The loop walks from the farthest offset to the nearest, so the nearest
  // pending requester is the last one assigned and therefore wins.
  always_comb begin
    int          c;
    logic [GW-1:0] cand;
    rr_id = grant_id;
    c     = 0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      c = int'(grant_id) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cand = GW'(c);
      if (req[cand]) rr_id = cand;
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_clear, lock_clear_nxt;
  logic lock_hold;

  // While the owner holds its lock, only the owner can win. This stays true
  // even while the owner is not requesting, which keeps the arbiter idle.
  always_comb begin
    lock_hold = lock[grant_id] && !lock_clear;
    win_id    = lock_hold ? grant_id : rr_id;
    win_go    = lock_hold ? req[grant_id] : |req;
  end
`else
  // Pure round-robin: grant whenever anyone is requesting.
  always_comb begin
    win_id = rr_id;
    win_go = |req;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      ack           <= '0;
      grant_id      <= GW'(NUM_REQ - 1);
      tx_data_valid <= 1'b0;
      tx_data       <= 8'h00;
      timeout_err   <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_clear    <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      ack           <= ack_nxt;
      grant_id      <= grant_nxt;
      tx_data_valid <= valid_nxt;
      tx_data       <= tx_data_nxt;
      timeout_err   <= timeout_nxt;
`ifdef UART_TX_ARB_LOCK_EN
      lock_clear    <= lock_clear_nxt;
`endif
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (win_go) state_nxt = LAUNCH;
      LAUNCH:     state_nxt = WAIT_START;
      WAIT_START: begin
        if (tx_busy)                  state_nxt = WAIT_DONE;
        else if (timer == TIMER_LAST) state_nxt = IDLE;
      end
      WAIT_DONE:  if (!tx_busy) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the start timer.
  always_comb begin
    ack_nxt     = '0;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    grant_nxt   = grant_id;
    tx_data_nxt = tx_data;
    timer_nxt   = timer;
`ifdef UART_TX_ARB_LOCK_EN
    lock_clear_nxt = lock_clear;
`endif
    case (state)
      IDLE: begin
        if (win_go) begin
          ack_nxt     = NUM_REQ'(1) << win_id;
          valid_nxt   = 1'b1;
          grant_nxt   = win_id;
          tx_data_nxt = data[8*win_id +: 8];
`ifdef UART_TX_ARB_LOCK_EN
          lock_clear_nxt = 1'b0;
`endif
        end
      end
      LAUNCH: timer_nxt = '0;
      WAIT_START: begin
        if (!tx_busy) begin
          if (timer == TIMER_LAST) begin
            timeout_nxt = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            // A transmitter that never started must not stay pinned to the
            // same owner, so the next grant after a timeout is round-robin.
            lock_clear_nxt = 1'b1;
`endif
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // active is decoded directly from state.
  always_comb active = (state != IDLE);

endmodule
